// File: rtl/ahb_lite_slave_pkg.sv
// ahb_lite_slave_pkg: shared AHB-Lite types/constants (HTRANS codes, HRESP values, word HSIZE, ROM tag, data-phase states)
package ahb_lite_slave_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NON_SEQ = 2'd2, SEQ = 2'd3} htrans_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_ERR1, D_ERR2} dstate_t;
  localparam logic OKAY = 1'b0;
  localparam logic ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [31:0] ROM_TAG = 32'hC0DE_0000;
endpackage

// File: rtl/ahb_word_ram.sv
// ahb_word_ram: word memory (clk, rst, we, addr, wdata -> rdata) with a sync write port, async read port, and a write-protected ROM region that is reloaded on rst
module ahb_word_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int ROM_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  import ahb_lite_slave_pkg::*;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < ROM_DEPTH; i++) mem[i] <= DATA_W'(ROM_TAG) | DATA_W'(i);
    else if (we && 32'(addr) >= ROM_DEPTH)
      mem[addr] <= wdata;
endmodule

// File: rtl/ahb_lite_slave.sv
// ahb_lite_slave: AHB-Lite word responder (HCLK/reset; HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA/HREADY in; HRDATA/HREADYOUT/HRESP out) with ROM region, wait states and two-cycle ERROR
module ahb_lite_slave #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int ROM_DEPTH = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              reset,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);
  import ahb_lite_slave_pkg::*;
  dstate_t state;
  logic [ADDR_W-1:0] addr_q;
  logic write_q, act_q, accept, err, unused_bits;
  logic [3:0] cnt;
  logic [DATA_W-1:0] rdata;
  assign unused_bits = ^{HBURST, HADDR[31:ADDR_W]};
  assign accept = HSEL && HREADY && (htrans_t'(HTRANS) == NON_SEQ || htrans_t'(HTRANS) == SEQ)
                  && (state == D_IDLE || state == D_ERR2);
  assign err = (HWRITE && 32'(HADDR[ADDR_W-1:0]) < ROM_DEPTH) || HSIZE != HSIZE_WORD;
  assign HRDATA = (act_q && !write_q) ? rdata : '0;
  ahb_word_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_DEPTH(ROM_DEPTH)) u_ram (
    .clk(HCLK), .rst(reset), .we(act_q && write_q && state == D_IDLE),
    .addr(addr_q), .wdata(HWDATA), .rdata(rdata)
  );
  // act_q marks a non-error data phase; D_IDLE with act_q set is its completion cycle
  always_ff @(posedge HCLK)
    if (reset) begin
      state <= D_IDLE;
      cnt <= '0;
      act_q <= 1'b0;
      addr_q <= '0;
      write_q <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP <= OKAY;
    end else if (accept) begin
      addr_q <= HADDR[ADDR_W-1:0];
      write_q <= HWRITE;
      act_q <= !err;
      cnt <= 4'(WAIT_STATES);
      state <= err ? D_ERR1 : (WAIT_STATES > 0 ? D_WAIT : D_IDLE);
      HREADYOUT <= !err && WAIT_STATES == 0;
      HRESP <= err ? ERROR : OKAY;
    end else if (state == D_WAIT) begin
      cnt <= cnt - 4'd1;
      state <= cnt <= 4'd1 ? D_IDLE : D_WAIT;
      HREADYOUT <= cnt <= 4'd1;
    end else if (state == D_ERR1) begin
      state <= D_ERR2;
      HREADYOUT <= 1'b1;
    end else begin
      state <= D_IDLE;
      act_q <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP <= OKAY;
    end
endmodule

// File: tb/tb_ahb_lite_slave.sv
// tb_ahb_lite_slave: three-slave AHB-Lite bus (0, 2, 3 wait states) driven from a vector table with a scoreboard queue
module tb_ahb_lite_slave;
  logic HCLK = 1'b0;
  logic reset = 1'b1;
  always #5 HCLK = ~HCLK;
  logic [2:0] sel, hsize, hburst;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0] htrans;
  logic hwrite, hready, hresp;
  logic ro [3];
  logic rs [3];
  logic [31:0] rd [3];
  assign hready = ro[0] & ro[1] & ro[2];
  assign hresp = rs[0] | rs[1] | rs[2];
  assign hrdata = rd[0] | rd[1] | rd[2];
  for (genvar g = 0; g < 3; g++) begin : gs
    ahb_lite_slave #(.WAIT_STATES(g == 0 ? 0 : g + 1)) u (
      .HCLK(HCLK), .reset(reset), .HSEL(sel[g]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
      .HRDATA(rd[g]), .HREADYOUT(ro[g]), .HRESP(rs[g])
    );
  end
  typedef struct {
    int s; int addr; bit wr; bit seq; logic [2:0] size; logic [31:0] wd;
    bit err; logic [31:0] rd; int waits;
  } vec_t;
  typedef struct { int idx; bit err; logic [31:0] rd; int waits; } exp_t;
  vec_t v [20];
  exp_t sb [$];
  int n_vec = 0;
  int n_bad = 0;
  function automatic vec_t mk(input int s, input int addr, input bit wr, input bit seq,
                              input logic [2:0] size, input logic [31:0] wd,
                              input bit err, input logic [31:0] rdx);
    vec_t r;
    r.s = s; r.addr = addr; r.wr = wr; r.seq = seq; r.size = size; r.wd = wd;
    r.err = err; r.rd = rdx;
    r.waits = err ? 1 : (s == 0 ? 0 : s + 1);
    return r;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive_addr(input int i);
    exp_t e;
    sel = 3'b001 << v[i].s;
    haddr = 32'(v[i].addr);
    hwrite = v[i].wr;
    hsize = v[i].size;
    htrans = v[i].seq ? 2'b11 : 2'b10;
    hburst = v[i].seq ? 3'b011 : 3'b000;
    e.idx = i; e.err = v[i].err; e.rd = v[i].rd; e.waits = v[i].waits;
    sb.push_back(e);
  endtask
  task automatic drive_idle();
    sel = 3'b000;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask
  task automatic run_vecs(input int lo, input int hi);
    @(negedge HCLK);
    drive_addr(lo);
    for (int i = lo; i <= hi; i++) begin
      int lows;
      int bad_resp;
      exp_t e;
      lows = 0;
      bad_resp = 0;
      @(posedge HCLK);
      #1;
      hwdata = v[i].wd;
      if (i < hi) drive_addr(i + 1);
      else drive_idle();
      e = sb.pop_front();
      do begin
        @(negedge HCLK);
        if (!hready) begin
          lows++;
          if (hresp !== e.err) bad_resp++;
        end
      end while (!hready && lows < 40);
      check($sformatf("v%0d.waits", e.idx), 32'(lows), 32'(e.waits));
      check($sformatf("v%0d.resp_low", e.idx), 32'(bad_resp), 32'd0);
      check($sformatf("v%0d.resp", e.idx), {31'd0, hresp}, {31'd0, e.err});
      check($sformatf("v%0d.rdata", e.idx), hrdata, e.rd);
    end
  endtask
  initial begin
    v[0]  = mk(0, 2,   0, 0, 3'b010, 0, 0, 32'hC0DE_0002);
    v[1]  = mk(0, 10,  1, 0, 3'b010, 32'hDEAD_BEEF, 0, 0);
    v[2]  = mk(0, 10,  0, 0, 3'b010, 0, 0, 32'hDEAD_BEEF);
    v[3]  = mk(0, 3,   1, 0, 3'b010, 32'h1111_1111, 1, 0);
    v[4]  = mk(0, 3,   0, 0, 3'b010, 0, 0, 32'hC0DE_0003);
    v[5]  = mk(0, 20,  0, 0, 3'b001, 0, 1, 0);
    v[6]  = mk(0, 20,  1, 0, 3'b010, 32'h1234_5678, 0, 0);
    v[7]  = mk(0, 20,  0, 0, 3'b010, 0, 0, 32'h1234_5678);
    v[8]  = mk(1, 100, 1, 0, 3'b010, 1, 0, 0);
    v[9]  = mk(1, 101, 1, 1, 3'b010, 2, 0, 0);
    v[10] = mk(1, 102, 1, 1, 3'b010, 3, 0, 0);
    v[11] = mk(1, 103, 1, 1, 3'b010, 4, 0, 0);
    v[12] = mk(1, 100, 0, 0, 3'b010, 0, 0, 1);
    v[13] = mk(1, 101, 0, 1, 3'b010, 0, 0, 2);
    v[14] = mk(1, 102, 0, 1, 3'b010, 0, 0, 3);
    v[15] = mk(1, 103, 0, 1, 3'b010, 0, 0, 4);
    v[16] = mk(1, 1,   1, 0, 3'b010, 32'h2222_2222, 1, 0);
    v[17] = mk(2, 50,  1, 0, 3'b010, 32'hAAAA_5555, 0, 0);
    v[18] = mk(2, 50,  0, 0, 3'b010, 0, 0, 32'hAAAA_5555);
    v[19] = mk(2, 50,  0, 0, 3'b010, 0, 0, 32'hAAAA_5555);
    drive_idle();
    haddr = '0; hsize = 3'b010; hburst = '0; hwdata = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("reset.hready", {31'd0, hready}, 32'd1);
    check("reset.hresp", {31'd0, hresp}, 32'd0);
    check("reset.hrdata", hrdata, 32'd0);
    reset = 1'b0;
    run_vecs(0, 18);
    sel = 3'b100; haddr = 32'd50; hwrite = 1'b1; hsize = 3'b010; htrans = 2'b10;
    @(posedge HCLK);
    #1;
    drive_idle();
    hwdata = 32'h0BAD_0BAD;
    @(negedge HCLK);
    check("midwait.w1", {31'd0, hready}, 32'd0);
    @(posedge HCLK);
    #1;
    reset = 1'b1;
    @(negedge HCLK);
    check("midwait.w2", {31'd0, hready}, 32'd0);
    @(posedge HCLK);
    #1;
    reset = 1'b0;
    @(negedge HCLK);
    check("midwait.hready", {31'd0, hready}, 32'd1);
    check("midwait.hresp", {31'd0, hresp}, 32'd0);
    run_vecs(19, 19);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
